// File: rtl/key_expansion_seq_if.sv
// Round-key stream interface: a start request with the cipher key in one
// direction, and valid/ready round keys plus status pulses in the other.
interface key_expansion_seq_if #(
    parameter int NK_MAX = 8
) ();
    logic                    start;
    logic [1:0]              key_len;
    logic [0:32*NK_MAX-1]    key_in;
    logic                    rk_valid;
    logic                    rk_ready;
    logic [0:127]            rk_data;
    logic [3:0]              rk_index;
    logic                    busy;
    logic                    done;
    logic                    err;

    modport master (
        output start, key_len, key_in, rk_ready,
        input  rk_valid, rk_data, rk_index, busy, done, err
    );

    modport slave (
        input  start, key_len, key_in, rk_ready,
        output rk_valid, rk_data, rk_index, busy, done, err
    );
endinterface

// File: rtl/key_expansion_seq.sv
// AES key expansion, one schedule word per cycle, emitting round keys over a
// valid/ready stream. Supports AES-128/192/256 up to NK_MAX key words.

// Forward AES S-box: GF(2^8) inverse (x^254) followed by the affine map.
module sbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] sub_byte(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        // x^254 = product of x^2, x^4, ... x^128; maps 0 to 0 as the S-box needs.
        sq  = x;
        inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv
             ^ {inv[6:0], inv[7]}
             ^ {inv[5:0], inv[7:6]}
             ^ {inv[4:0], inv[7:5]}
             ^ {inv[3:0], inv[7:4]}
             ^ 8'h63;
    endfunction

    assign o_byte = sub_byte(i_byte);
endmodule

module key_expansion_seq #(
    parameter int NK_MAX = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    key_expansion_seq_if.slave  bus
);
    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_RUN    = 1'b1;
    localparam logic [3:0] NK_LIMIT = 4'(NK_MAX);

    logic [0:0]             r_state;
    logic [3:0]             r_nk;
    logic [3:0]             r_nr;
    logic [0:32*NK_MAX-1]   r_key;
    logic [31:0]            r_hist [0:7];
    logic [5:0]             r_idx;
    logic [2:0]             r_kmod;
    logic                   r_gen;
    logic [7:0]             r_rcon;
    logic [31:0]            r_asm [0:2];
    logic [0:127]           r_rk_data;
    logic [3:0]             r_rk_index;
    logic                   r_rk_valid;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_err;

    logic [3:0]             w_nk_req;
    logic                   w_legal;
    logic                   w_stall;
    logic                   w_en;
    logic                   w_xfer;
    logic                   w_last_xfer;
    logic                   w_is_key;
    logic [31:0]            w_prev;
    logic [31:0]            w_back;
    logic [31:0]            w_sub_in;
    logic [31:0]            w_sub_out;
    logic [31:0]            w_word;
    logic [31:0]            w_key_word [0:7];

    assign w_nk_req    = {1'b0, bus.key_len, 1'b0} + 4'd4;
    assign w_legal     = (bus.key_len != 2'd3) && (w_nk_req <= NK_LIMIT);
    // Only a word that would overwrite a still-pending round key has to wait.
    assign w_stall     = (r_idx[1:0] == 2'b11) && r_rk_valid && !bus.rk_ready;
    assign w_en        = r_gen && !w_stall;
    assign w_xfer      = r_rk_valid && bus.rk_ready;
    assign w_last_xfer = w_xfer && (r_rk_index == r_nr);
    assign w_is_key    = r_idx < {2'b00, r_nk};
    assign w_prev      = r_hist[0];
    assign w_back      = r_hist[r_nk[2:0] - 3'd1];
    assign w_sub_in    = (r_kmod == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;

    for (genvar g = 0; g < 8; g++) begin : g_key_word
        if (g < NK_MAX) begin : g_used
            assign w_key_word[g] = r_key[32*g +: 32];
        end else begin : g_unused
            assign w_key_word[g] = 32'h0;
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        sbox u_sbox (
            .i_byte (w_sub_in[8*g +: 8]),
            .o_byte (w_sub_out[8*g +: 8])
        );
    end

    // NOTE: every branch assigns w_word after a default, so no latch is inferred.
    always_comb begin
        w_word = w_back ^ w_prev;
        if (w_is_key) begin
            w_word = w_key_word[r_idx[2:0]];
        end else if (r_kmod == 3'd0) begin
            w_word = w_back ^ w_sub_out ^ {r_rcon, 24'h0};
        end else if (r_nk == 4'd8 && r_kmod == 3'd4) begin
            w_word = w_back ^ w_sub_out;
        end
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_nk       <= 4'd0;
            r_nr       <= 4'd0;
            r_key      <= '0;
            // NOTE: the history and assembly arrays are reset too, so an aborted run leaves nothing behind.
            for (int j = 0; j < 8; j++) r_hist[j] <= 32'h0;
            for (int j = 0; j < 3; j++) r_asm[j] <= 32'h0;
            r_idx      <= 6'd0;
            r_kmod     <= 3'd0;
            r_gen      <= 1'b0;
            r_rcon     <= 8'h01;
            r_rk_data  <= '0;
            r_rk_index <= 4'd0;
            r_rk_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        if (w_legal) begin
                            r_state <= S_RUN;
                            r_busy  <= 1'b1;
                            r_gen   <= 1'b1;
                            r_key   <= bus.key_in;
                            r_nk    <= w_nk_req;
                            r_nr    <= w_nk_req + 4'd6;
                            r_idx   <= 6'd0;
                            r_kmod  <= 3'd0;
                            r_rcon  <= 8'h01;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                default: begin
                    if (w_last_xfer) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
            endcase

            if (w_en) begin
                r_hist[0] <= w_word;
                for (int j = 1; j < 8; j++) r_hist[j] <= r_hist[j-1];
                r_idx  <= r_idx + 6'd1;
                r_kmod <= ({1'b0, r_kmod} == r_nk - 4'd1) ? 3'd0 : r_kmod + 3'd1;
                if (!w_is_key && r_kmod == 3'd0) begin
                    r_rcon <= {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);
                end
                if (r_idx == {r_nr, 2'b11}) r_gen <= 1'b0;
                case (r_idx[1:0])
                    2'd0:    r_asm[0] <= w_word;
                    2'd1:    r_asm[1] <= w_word;
                    2'd2:    r_asm[2] <= w_word;
                    default: ;
                endcase
            end

            if (w_en && r_idx[1:0] == 2'b11) begin
                r_rk_data  <= {r_asm[0], r_asm[1], r_asm[2], w_word};
                r_rk_index <= r_idx[5:2];
                r_rk_valid <= 1'b1;
            end else if (w_xfer) begin
                r_rk_valid <= 1'b0;
            end
        end
    end

    assign bus.rk_valid = r_rk_valid;
    assign bus.rk_data  = r_rk_data;
    assign bus.rk_index = r_rk_index;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.err      = r_err;
endmodule

// File: tb/tb_key_expansion_seq.sv
// Bench for key_expansion_seq: reference key schedule feeds a round-key
// scoreboard; covers vectors, backpressure, rejected starts and reset.
module tb_key_expansion_seq;
    typedef struct packed {
        logic [3:0]   idx;
        logic [127:0] data;
    } rk_t;

    localparam logic [7:0] SBOX_TBL [256] = '{
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
    };

    localparam logic [255:0] KEY128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] KEY192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] KEY256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    key_expansion_seq_if #(.NK_MAX(8)) bus8 ();
    key_expansion_seq_if #(.NK_MAX(4)) bus4 ();

    key_expansion_seq #(.NK_MAX(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8)
    );

    key_expansion_seq #(.NK_MAX(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    int           n_vec = 0;
    int           n_err = 0;
    int           n_xfer = 0;
    rk_t          sb_q [$];
    logic [31:0]  m_w [0:59];
    logic [127:0] got_rk [0:15];
    logic [127:0] held_d;
    bit           held_v = 1'b0;

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] x);
        return {SBOX_TBL[x[31:24]], SBOX_TBL[x[23:16]], SBOX_TBL[x[15:8]], SBOX_TBL[x[7:0]]};
    endfunction

    // Reference schedule straight from the AES word recurrence.
    task automatic model(input int nk, input logic [255:0] key);
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4 * (nk + 7); i++) begin
            if (i < nk) begin
                m_w[i] = key[255 - 32*i -: 32];
            end else begin
                t = m_w[i-1];
                if (i % nk == 0) begin
                    t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                    rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
                end else if (nk == 8 && i % 8 == 4) begin
                    t = sub_word(t);
                end
                m_w[i] = m_w[i-nk] ^ t;
            end
        end
    endtask

    task automatic push_expected(input logic [1:0] len, input logic [255:0] key);
        int nk;
        nk = 4 + 2 * int'(len);
        model(nk, key);
        for (int k = 0; k <= nk + 6; k++) begin
            sb_q.push_back('{idx: 4'(k), data: {m_w[4*k], m_w[4*k+1], m_w[4*k+2], m_w[4*k+3]}});
        end
        for (int k = 0; k < 16; k++) got_rk[k] = '0;
        n_xfer = 0;
    endtask

    // Transfers are sampled mid-cycle; the following rising edge completes them.
    always @(negedge clk) begin
        rk_t e;
        if (rst_n && bus8.rk_valid) begin
            if (held_v) check("stall_hold", bus8.rk_data, held_d);
            if (bus8.rk_ready) begin
                held_v = 1'b0;
                n_xfer++;
                got_rk[bus8.rk_index] = bus8.rk_data;
                check("sb_nonempty", 128'(sb_q.size() != 0), 128'(1));
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    check("rk_index", 128'(bus8.rk_index), 128'(e.idx));
                    check("rk_data", bus8.rk_data, e.data);
                end
            end else begin
                held_v = 1'b1;
                held_d = bus8.rk_data;
            end
        end else begin
            held_v = 1'b0;
        end
    end

    task automatic run_key(input logic [1:0] len, input logic [255:0] key, input int pct,
                           input bit lat, input bit mid_start);
        int nr, cyc, t_first, t_last, t_done;
        nr = 10 + 2 * int'(len);
        push_expected(len, key);
        bus8.start   = 1'b1;
        bus8.key_len = len;
        bus8.key_in  = key;
        bus8.rk_ready = ($urandom_range(0, 99) < pct);
        @(posedge clk); #1;
        bus8.start   = 1'b0;
        bus8.key_in  = ~key;
        bus8.key_len = 2'd3;
        check("busy_on_start", 128'(bus8.busy), 128'(1));
        cyc = 0; t_first = -1; t_last = -1; t_done = -1;
        while (cyc < 3000 && t_done < 0) begin
            if (mid_start && cyc == 9) begin
                bus8.start   = 1'b1;
                bus8.key_len = 2'd0;
                bus8.key_in  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            end else begin
                bus8.start = 1'b0;
            end
            bus8.rk_ready = ($urandom_range(0, 99) < pct);
            @(posedge clk); #1;
            cyc++;
            if (mid_start && cyc == 10) check("mid_start_no_err", 128'(bus8.err), 128'(0));
            if (t_first < 0 && bus8.rk_valid && bus8.rk_index == 4'd0) t_first = cyc;
            if (t_last < 0 && bus8.rk_valid && bus8.rk_index == 4'(nr)) t_last = cyc;
            if (bus8.done) t_done = cyc;
        end
        bus8.start = 1'b0;
        check("done_seen", 128'(t_done > 0), 128'(1));
        if (lat) begin
            check("first_key_lat", 128'(t_first), 128'(4));
            check("last_key_lat", 128'(t_last), 128'(4 * nr + 4));
            check("done_lat", 128'(t_done), 128'(4 * nr + 5));
        end
        check("busy_after_done", 128'(bus8.busy), 128'(0));
        check("transfers", 128'(n_xfer), 128'(nr + 1));
        check("sb_drained", 128'(sb_q.size()), 128'(0));
        @(posedge clk); #1;
        check("done_one_cycle", 128'(bus8.done), 128'(0));
    endtask

    initial begin
        bit found;
        int seen;
        rst_n = 1'b0;
        bus8.start = 1'b0; bus8.key_len = 2'd0; bus8.key_in = '0; bus8.rk_ready = 1'b1;
        bus4.start = 1'b0; bus4.key_len = 2'd0; bus4.key_in = '0; bus4.rk_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 128'(bus8.rk_valid), 128'(0));
        check("rst_data", bus8.rk_data, 128'(0));
        check("rst_index", 128'(bus8.rk_index), 128'(0));
        check("rst_busy", 128'(bus8.busy), 128'(0));
        check("rst_done", 128'(bus8.done), 128'(0));
        check("rst_err", 128'(bus8.err), 128'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_key(2'd0, KEY128, 100, 1'b1, 1'b0);
        check("aes128_rk0", got_rk[0], KEY128[255:128]);
        check("aes128_rk10", got_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        run_key(2'd1, KEY192, 100, 1'b1, 1'b0);
        check("aes192_w6", 128'(got_rk[1][63:32]), 128'(32'hfe0c91f7));
        check("aes192_w51", 128'(got_rk[12][31:0]), 128'(32'h01002202));

        run_key(2'd2, KEY256, 100, 1'b1, 1'b0);
        check("aes256_w8", 128'(got_rk[2][127:96]), 128'(32'h9ba35411));
        check("aes256_w59", 128'(got_rk[14][31:0]), 128'(32'h706c631e));

        run_key(2'd0, KEY128, 30, 1'b0, 1'b0);
        check("bp128_rk10", got_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        run_key(2'd2, KEY256, 30, 1'b0, 1'b1);
        run_key(2'd1, KEY192, 100, 1'b1, 1'b1);

        bus8.start = 1'b1; bus8.key_len = 2'd3;
        @(posedge clk); #1;
        bus8.start = 1'b0;
        check("len3_err", 128'(bus8.err), 128'(1));
        check("len3_busy", 128'(bus8.busy), 128'(0));
        @(posedge clk); #1;
        check("len3_err_pulse", 128'(bus8.err), 128'(0));
        check("len3_busy_after", 128'(bus8.busy), 128'(0));

        bus4.start = 1'b1; bus4.key_len = 2'd2; bus4.key_in = KEY128[255:128];
        @(posedge clk); #1;
        check("nk4_len2_err", 128'(bus4.err), 128'(1));
        check("nk4_len2_busy", 128'(bus4.busy), 128'(0));
        bus4.key_len = 2'd0;
        @(posedge clk); #1;
        bus4.start = 1'b0;
        check("nk4_len0_err", 128'(bus4.err), 128'(0));
        check("nk4_len0_busy", 128'(bus4.busy), 128'(1));

        push_expected(2'd0, KEY128);
        bus8.rk_ready = 1'b1;
        bus8.start = 1'b1; bus8.key_len = 2'd0; bus8.key_in = KEY128;
        @(posedge clk); #1;
        bus8.start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 200 && !found; c++) begin
            @(posedge clk); #1;
            if (bus8.rk_valid && bus8.rk_index == 4'd3) found = 1'b1;
        end
        check("rk3_seen", 128'(found), 128'(1));
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("mrst_valid", 128'(bus8.rk_valid), 128'(0));
        check("mrst_data", bus8.rk_data, 128'(0));
        check("mrst_index", 128'(bus8.rk_index), 128'(0));
        check("mrst_busy", 128'(bus8.busy), 128'(0));
        check("mrst_done", 128'(bus8.done), 128'(0));
        check("mrst_err", 128'(bus8.err), 128'(0));
        rst_n = 1'b1;
        sb_q.delete();
        seen = 0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk); #1;
            if (bus8.rk_valid || bus8.done || bus8.busy) seen++;
        end
        check("no_output_after_abort", 128'(seen), 128'(0));

        run_key(2'd0, KEY128, 100, 1'b1, 1'b0);
        check("rerun_rk10", got_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d miscompares so far", n_err);
        $fatal(1, "watchdog expired");
    end
endmodule
